// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings, cfg_reg bit positions and frame-length helper.
package uart_rx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int CFG_LEN  = 0;  // two bits: data length - 5
    localparam int CFG_STOP = 2;
    localparam int CFG_PEN  = 3;
    localparam int CFG_PODD = 4;

    function automatic logic [3:0] data_len(input logic [4:0] cfg);
        return {2'b00, cfg[CFG_LEN +: 2]} + 4'd5;
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs; reset value chosen per use.
module uart_rx_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, 3-sample majority per bit, parity and stop checking.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_tick,
    input  logic       rx_enable,
    input  logic [4:0] cfg_reg,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MID_LO = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_MID_HI = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);

    logic             rxs;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [4:0]       cfg_lat;
    logic [7:0]       shreg;
    logic             s_lo, s_mid;
    logic             armed;
    logic             perr_next, ferr_next;
    logic             maj, last_data, last_stop, stop_bad;

    uart_rx_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    assign maj       = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);
    assign last_data = (bit_idx == 3'(data_len(cfg_lat) - 4'd1));
    assign last_stop = (bit_idx[0] == cfg_lat[CFG_STOP]);
    assign stop_bad  = ferr_next | ~maj;
    assign rx_busy   = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            cfg_lat    <= '0;
            shreg      <= '0;
            s_lo       <= 1'b1;
            s_mid      <= 1'b1;
            armed      <= 1'b0;
            perr_next  <= 1'b0;
            ferr_next  <= 1'b0;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (state == ST_IDLE && rxs)
                armed <= 1'b1;

            if (state == ST_IDLE) begin
                // A tick coinciding with the start edge is deliberately not counted.
                if (rx_enable && armed && !rxs) begin
                    state     <= ST_START;
                    cfg_lat   <= cfg_reg;
                    cnt       <= '0;
                    bit_idx   <= '0;
                    shreg     <= '0;
                    perr_next <= 1'b0;
                    ferr_next <= 1'b0;
                end
            end else if (!rx_enable) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                bit_idx <= '0;
            end else if (sample_tick) begin
                // NOTE: later non-blocking assignments in this block override this default
                // increment; the last assignment to a flop in a clock cycle is the one that lands.
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                if (cnt == CNT_MID_LO) s_lo  <= rxs;
                if (cnt == CNT_MID)    s_mid <= rxs;

                case (state)
                    ST_START: begin
                        if (cnt == CNT_MID_HI && maj) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (cnt == CNT_MID_HI)
                            shreg[bit_idx] <= maj;
                        if (cnt == CNT_LAST) begin
                            if (last_data) begin
                                bit_idx <= '0;
                                state   <= cfg_lat[CFG_PEN] ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (cnt == CNT_MID_HI)
                            perr_next <= (maj != ((^shreg) ^ cfg_lat[CFG_PODD]));
                        if (cnt == CNT_LAST) begin
                            state   <= ST_STOP;
                            bit_idx <= '0;
                        end
                    end
                    ST_STOP: begin
                        // Finish mid-way through the last stop bit so a back-to-back start edge is seen.
                        if (cnt == CNT_MID_HI) begin
                            if (last_stop) begin
                                rx_data    <= shreg;
                                parity_err <= perr_next;
                                frame_err  <= stop_bad;
                                rx_done    <= 1'b1;
                                state      <= ST_IDLE;
                                cnt        <= '0;
                                bit_idx    <= '0;
                                if (stop_bad)
                                    armed <= 1'b0;
                            end else begin
                                ferr_next <= stop_bad;
                            end
                        end else if (cnt == CNT_LAST) begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
